mux_scan_reg: RTL and testbench

Parametrised, registered N-channel data selector with a valid/ready output stage and an automatic channel-scan mode. It generalises the fixed 4×16-bit clocked multiplexer into a block with configurable width and channel count, per-channel valid qualifiers, backpressure, and a dwell-timed round-robin scanner. It sits between a bank of producer channels and a single downstream consumer.

---
 rtl/mux_scan_reg.sv | 123 ++++++++++++
 tb/tb_mux_scan_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_reg.sv
// mux_scan_reg
// Registered N-channel data selector with a valid/ready output stage.
// In manual mode the channel comes from i_ctrl. In scan mode a round-robin
// pointer visits every channel for DWELL load-enabled cycles, whether or not
// that channel has data.

module mux_scan_reg #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DWELL    = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]       i_valid,
    input  logic [SEL_W-1:0]          i_ctrl,
    input  logic                      i_mode,
    input  logic                      i_ready,
    output logic [WIDTH-1:0]          o_data,
    output logic [SEL_W-1:0]          o_chan,
    output logic                      o_valid
);

    // The dwell counter needs at least one bit, even when DWELL is 1.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CHAN_LAST  = SEL_W'(CHANNELS - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t            state_q,    state_d;
    logic [WIDTH-1:0]  outData_q,  outData_d;
    logic [SEL_W-1:0]  outChan_q,  outChan_d;
    logic              outValid_q, outValid_d;
    logic [SEL_W-1:0]  scanPtr_q,  scanPtr_d;
    logic [CNT_W-1:0]  dwellCnt_q, dwellCnt_d;

    logic              loadEn;
    logic [SEL_W-1:0]  sel;
    logic [WIDTH-1:0]  selData;
    logic              selHit;

    // The output slot accepts a new beat when it is empty or is being drained this cycle.
    assign loadEn = !outValid_q || i_ready;

    // In the cycle the mode flips, the current state (not the new one) picks the channel.
    assign sel = (state_q == SCAN) ? scanPtr_q : i_ctrl;

    // Look up the selected channel. An index past the last channel matches nothing,
    // so the slot sees it as an empty channel.
    always_comb begin
        selData = '0;
        selHit  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) begin
                selData = i_data[k*WIDTH +: WIDTH];
                selHit  = i_valid[k];
            end
        end
    end

    // Work out the next output beat, the next mode and the next scanner position.
    always_comb begin
        state_d    = i_mode ? SCAN : MANUAL;
        outData_d  = outData_q;
        outChan_d  = outChan_q;
        outValid_d = outValid_q;
        scanPtr_d  = scanPtr_q;
        dwellCnt_d = dwellCnt_q;

        if (loadEn) begin
            if (selHit) begin
                outData_d  = selData;
                outChan_d  = sel;
                outValid_d = 1'b1;
            end else begin
                outValid_d = 1'b0;
            end
        end

        // Each entry into scan restarts the round at channel 0. A stall does not
        // use up dwell, so every channel is sampled for exactly DWELL load-enabled cycles.
        if (state_q == MANUAL && i_mode) begin
            scanPtr_d  = '0;
            dwellCnt_d = '0;
        end else if (state_q == SCAN && loadEn) begin
            if (dwellCnt_q == DWELL_LAST) begin
                dwellCnt_d = '0;
                scanPtr_d  = (scanPtr_q == CHAN_LAST) ? '0 : scanPtr_q + 1'b1;
            end else begin
                dwellCnt_d = dwellCnt_q + 1'b1;
            end
        end
    end

    // State and output registers. Reset clears them at once and drops any beat in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= MANUAL;
            outData_q  <= '0;
            outChan_q  <= '0;
            outValid_q <= 1'b0;
            scanPtr_q  <= '0;
            dwellCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            outData_q  <= outData_d;
            outChan_q  <= outChan_d;
            outValid_q <= outValid_d;
            scanPtr_q  <= scanPtr_d;
            dwellCnt_q <= dwellCnt_d;
        end
    end

    assign o_data  = outData_q;
    assign o_chan  = outChan_q;
    assign o_valid = outValid_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg
// Directed bench for mux_scan_reg. The main instance uses the default build
// (4 channels, 16 bits, dwell 4). A second instance has 3 channels, so an
// out-of-range manual select can be driven into it.

module tb_mux_scan_reg;

   logic        clock = 1'b0;
   logic        rstN;

   logic [15:0] chData [4];
   logic [63:0] iData;
   logic [3:0]  iValid;
   logic [1:0]  iCtrl;
   logic        iMode;
   logic        iReady;
   logic [15:0] oData;
   logic [1:0]  oChan;
   logic        oValid;

   logic [47:0] iData3;
   logic [2:0]  iValid3;
   logic [1:0]  iCtrl3;
   logic        iMode3;
   logic        iReady3;
   logic [15:0] oData3;
   logic [1:0]  oChan3;
   logic        oValid3;

   int checkCount = 0;
   int passCount  = 0;

   int expChan;

   assign iData  = {chData[3], chData[2], chData[1], chData[0]};
   assign iData3 = {chData[2], chData[1], chData[0]};

   // Free-running clock with a 10 ns period.
   always #5 clock = ~clock;

   mux_scan_reg #(.WIDTH(16), .CHANNELS(4), .DWELL(4)) dut (
      .i_clk   (clock),
      .i_rst_n (rstN),
      .i_data  (iData),
      .i_valid (iValid),
      .i_ctrl  (iCtrl),
      .i_mode  (iMode),
      .i_ready (iReady),
      .o_data  (oData),
      .o_chan  (oChan),
      .o_valid (oValid)
   );

   mux_scan_reg #(.WIDTH(16), .CHANNELS(3), .DWELL(4)) dut3 (
      .i_clk   (clock),
      .i_rst_n (rstN),
      .i_data  (iData3),
      .i_valid (iValid3),
      .i_ctrl  (iCtrl3),
      .i_mode  (iMode3),
      .i_ready (iReady3),
      .o_data  (oData3),
      .o_chan  (oChan3),
      .o_valid (oValid3)
   );

   // Advance one clock edge, then settle 1 ns so the outputs are sampled away from the edge.
   task automatic applyStimulus;
      @(posedge clock);
      #1;
   endtask

   // Compare one observed value against its expected value and keep the running counts.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Check the whole output beat of the main instance.
   task automatic checkBeat(input string tag, input logic [15:0] expData,
                            input logic [1:0] expChanV, input logic expValid);
      checkOutput({tag, ".data"},  32'(oData),  32'(expData));
      checkOutput({tag, ".chan"},  32'(oChan),  32'(expChanV));
      checkOutput({tag, ".valid"}, 32'(oValid), 32'(expValid));
   endtask

   // Watchdog: stop the run if the directed sequence ever stops advancing.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      rstN      = 1'b0;
      chData[0] = 16'h0000;
      chData[1] = 16'h00ff;
      chData[2] = 16'hff00;
      chData[3] = 16'hffff;
      iValid    = 4'b0000;
      iCtrl     = 2'd0;
      iMode     = 1'b0;
      iReady    = 1'b1;
      iValid3   = 3'b000;
      iCtrl3    = 2'd0;
      iMode3    = 1'b0;
      iReady3   = 1'b1;

      // Reset state
      #3;
      checkBeat("reset", 16'h0000, 2'd0, 1'b0);
      applyStimulus();
      applyStimulus();
      checkBeat("resetHeld", 16'h0000, 2'd0, 1'b0);
      rstN = 1'b1;

      // Manual select: every channel is valid and ctrl steps 0..3, five cycles each
      iValid = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         iCtrl = 2'(c);
         for (int n = 0; n < 5; n++) begin
            applyStimulus();
            checkBeat($sformatf("manual%0d_%0d", c, n), chData[c], 2'(c), 1'b1);
         end
      end

      // Backpressure: channel 2 is held while ready is low, and new data waits
      iCtrl = 2'd2;
      applyStimulus();
      checkBeat("bpLoad", 16'hff00, 2'd2, 1'b1);
      iReady = 1'b0;
      applyStimulus();
      checkBeat("bpStall0", 16'hff00, 2'd2, 1'b1);
      chData[2] = 16'h1234;
      applyStimulus();
      checkBeat("bpStall1", 16'hff00, 2'd2, 1'b1);
      applyStimulus();
      checkBeat("bpStall2", 16'hff00, 2'd2, 1'b1);
      iReady = 1'b1;
      applyStimulus();
      checkBeat("bpRelease", 16'h1234, 2'd2, 1'b1);

      // Asynchronous reset taken mid-stream while a beat is valid
      rstN = 1'b0;
      #1;
      checkBeat("asyncReset", 16'h0000, 2'd0, 1'b0);
      applyStimulus();
      checkBeat("asyncResetHeld", 16'h0000, 2'd0, 1'b0);
      rstN = 1'b1;

      // Invalid channel: the slot empties and the last data and channel are held
      iCtrl = 2'd1;
      applyStimulus();
      checkBeat("invPrime", 16'h00ff, 2'd1, 1'b1);
      iValid = 4'b1011;
      iCtrl  = 2'd2;
      applyStimulus();
      checkBeat("invChan", 16'h00ff, 2'd1, 1'b0);

      // Three-channel build: ctrl=3 selects no channel
      iValid3 = 3'b111;
      iCtrl3  = 2'd2;
      applyStimulus();
      checkOutput("ch3Load.data",  32'(oData3),  32'h1234);
      checkOutput("ch3Load.valid", 32'(oValid3), 32'd1);
      iCtrl3 = 2'd3;
      applyStimulus();
      checkOutput("ch3OutOfRange.valid", 32'(oValid3), 32'd0);
      checkOutput("ch3OutOfRange.data",  32'(oData3),  32'h1234);
      checkOutput("ch3OutOfRange.chan",  32'(oChan3),  32'd2);

      // Scan mode: the entry edge still uses ctrl, then channels 0..3 four beats each, then wrap
      chData[2] = 16'hff00;
      iValid    = 4'b1111;
      iCtrl     = 2'd3;
      iMode     = 1'b1;
      applyStimulus();
      checkBeat("scanEntry", 16'hffff, 2'd3, 1'b1);
      for (int i = 0; i < 20; i++) begin
         applyStimulus();
         expChan = (i / 4) % 4;
         checkBeat($sformatf("scan%0d", i), chData[expChan], 2'(expChan), 1'b1);
      end

      // Scan with a stall on channel 1: the stall holds the beat and uses no dwell
      applyStimulus();
      checkBeat("scanStallA", 16'h00ff, 2'd1, 1'b1);
      iReady = 1'b0;
      applyStimulus();
      checkBeat("scanStall0", 16'h00ff, 2'd1, 1'b1);
      applyStimulus();
      checkBeat("scanStall1", 16'h00ff, 2'd1, 1'b1);
      iReady = 1'b1;
      applyStimulus();
      checkBeat("scanStallB", 16'h00ff, 2'd1, 1'b1);
      applyStimulus();
      checkBeat("scanStallC", 16'h00ff, 2'd1, 1'b1);
      applyStimulus();
      checkBeat("scanStallD", 16'h00ff, 2'd1, 1'b1);
      applyStimulus();
      checkBeat("scanStallNext", 16'hff00, 2'd2, 1'b1);

      // Back to manual: once the mode change has settled, ctrl drives the select again
      iMode = 1'b0;
      iCtrl = 2'd0;
      applyStimulus();
      applyStimulus();
      checkBeat("backToManual", 16'h0000, 2'd0, 1'b1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
